// File: rtl/pipe_pkg.sv
// Shared types and constants for the mycpu pipeline-stage registers.
//   stage_state_t : fill level of an elastic stage (empty / one / two entries)
//   OCC_*         : occupancy encodings matching each state
//   PC_RESET      : architectural reset PC, typical RESET_VAL for a PC field
package pipe_pkg;

  localparam int unsigned OCC_W  = 2;
  localparam int unsigned STAT_W = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_t;

  localparam logic [OCC_W-1:0] OCC_EMPTY = OCC_W'(0);
  localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_TWO   = OCC_W'(2);

  localparam logic [31:0] PC_RESET = 32'hbfc00000;

endpackage

// File: rtl/pipe_stage_stats.sv
// Saturating stall-cycle counter for an elastic pipeline stage.
// Ports:
//   clk, reset : clock and synchronous active-high reset (clears the count)
//   stall_i    : stage holds a valid entry that downstream did not take
//   cnt_o      : number of stall cycles seen, saturating at all-ones
module pipe_stage_stats
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  output logic [STAT_W-1:0] cnt_o
);

  logic [STAT_W-1:0] cnt_q;
  logic [STAT_W-1:0] cnt_d;

  // Increment on stall, stop at the maximum value.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_i && (cnt_q != {STAT_W{1'b1}})) begin
      cnt_d = cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with a one-entry skid buffer.
// in_ready depends only on the state register, never on out_ready.
// Optional stall statistics: define PIPE_STAGE_STATS_EN.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   flush               : synchronous kill of all held entries
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake and payload
//   occupancy           : entries currently held (0..2)
//   stall_cnt           : saturating stall-cycle count (0 when stats disabled)
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [OCC_W-1:0]  occupancy,
  output logic [STAT_W-1:0] stall_cnt
);

  stage_state_t     state_q, state_d;
  logic [WIDTH-1:0] main_q,  main_d;
  logic [WIDTH-1:0] skid_q,  skid_d;
  logic             in_fire;
  logic             out_fire;

  // Handshake signals decoded from state only.
  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_TWO);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    occupancy = OCC_EMPTY;
    case (state_q)
      ST_ONE:  occupancy = OCC_ONE;
      ST_TWO:  occupancy = OCC_TWO;
      default: occupancy = OCC_EMPTY;
    endcase
  end

  // Next state and payload; flush overrides any transfer this cycle.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = ST_TWO;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // Skid entry moves up to main when downstream takes main.
          if (out_fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = RESET_VAL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  pipe_stage_stats u_stats (
    .clk     (clk),
    .reset   (reset),
    .stall_i (out_valid & ~out_ready),
    .cnt_o   (stall_cnt)
  );
`else
  assign stall_cnt = STAT_W'(0);
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed self-checking bench for pipe_stage_elastic (WIDTH=32, RESET_VAL=PC reset).
module tb_pipe_stage_elastic;
  import pipe_pkg::*;

  localparam logic [31:0] RV = 32'hbfc00000;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [31:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  pipe_stage_elastic #(
    .WIDTH     (32),
    .RESET_VAL (RV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic v, input logic r,
                             input logic [1:0] occ, input logic [31:0] d);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    check({tag, ".in_ready"},  32'(in_ready),  32'(r));
    check({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
    check({tag, ".out_data"},  out_data, d);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset for two cycles, then idle.
    step(); step();
    reset = 1'b0;
    step();
    check_state("reset_idle", 1'b0, 1'b1, 2'd0, RV);
    check("reset_stall", stall_cnt, 32'h0);

    // Streaming at full throughput.
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      step();
      check_state($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, 32'(i));
    end
    in_valid = 1'b0;
    step();
    check_state("stream_drain", 1'b0, 1'b1, 2'd0, 32'd4);

    // Back-pressure fills main then skid.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    step();
    check_state("bp_one", 1'b1, 1'b1, 2'd1, 32'hA);
    in_data = 32'hB;
    step();
    check_state("bp_two", 1'b1, 1'b0, 2'd2, 32'hA);
    in_data = 32'hC;  // must be ignored, in_ready is low
    step();
    check_state("bp_hold", 1'b1, 1'b0, 2'd2, 32'hA);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check_state("bp_drain1", 1'b1, 1'b1, 2'd1, 32'hB);
    step();
    check_state("bp_drain2", 1'b0, 1'b1, 2'd0, 32'hB);

    // Flush while full, with coincident input.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    step();
    in_data = 32'h22;
    step();
    check_state("fl_pre", 1'b1, 1'b0, 2'd2, 32'h11);
    flush   = 1'b1;
    in_data = 32'h33;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_state("fl_two", 1'b0, 1'b1, 2'd0, RV);
    out_ready = 1'b1;
    step();
    check_state("fl_two_after", 1'b0, 1'b1, 2'd0, RV);

    // Flush in ONE while a transfer would otherwise be accepted.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h44;
    step();
    check_state("fl1_pre", 1'b1, 1'b1, 2'd1, 32'h44);
    flush   = 1'b1;
    in_data = 32'h33;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_state("fl_one", 1'b0, 1'b1, 2'd0, RV);

    // Reset beats flush and input.
    in_valid = 1'b1;
    in_data  = 32'h66;
    step();
    check_state("rst_pre", 1'b1, 1'b1, 2'd1, 32'h66);
    reset   = 1'b1;
    flush   = 1'b1;
    in_data = 32'h55;
    step();
    reset    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    check_state("rst_win", 1'b0, 1'b1, 2'd0, RV);
    check("rst_win_stall", stall_cnt, 32'h0);
    step();
    check_state("rst_after", 1'b0, 1'b1, 2'd0, RV);

    // Hold one entry stalled for seven cycles.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h77;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    check_state("stall_hold", 1'b1, 1'b1, 2'd1, 32'h77);
`ifdef PIPE_STAGE_STATS_EN
    check("stall_cnt7", stall_cnt, 32'd7);
    // Preload near the top and confirm saturation.
    dut.u_stats.cnt_q = 32'hFFFFFFFD;
    step();
    check("sat_fe", stall_cnt, 32'hFFFFFFFE);
    step();
    check("sat_ff", stall_cnt, 32'hFFFFFFFF);
    step();
    check("sat_hold", stall_cnt, 32'hFFFFFFFF);
`else
    check("stall_cnt_off", stall_cnt, 32'h0);
`endif
    out_ready = 1'b1;
    step();
    check_state("final_drain", 1'b0, 1'b1, 2'd0, 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
